// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment driver with per-frame digit snapshot,
// inter-digit guard, leading-zero blanking and a 1 Hz colon blink.
module seg7_scan #(
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 2,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_10,
  input  logic [3:0] hour1,
  input  logic [3:0] min_10,
  input  logic [3:0] min1,
  input  logic [3:0] sec_10,
  input  logic [3:0] sec1,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_en
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GRD     = CW'(GUARD);

  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [5:0][3:0] snap;
  logic            col;

  logic       wrap;
  logic       take;
  logic [3:0] cur;
  logic [6:0] glyph;
  logic [6:0] seg_a;
  logic       dp_a;
  logic [5:0] dig_a;

  assign wrap = (cnt == CNT_MAX);
  assign take = (cnt == '0) && (idx == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      idx  <= '0;
      snap <= '0;
      col  <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap)
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      // Whole-frame snapshot keeps a rollover from tearing mid-scan
      if (take) begin
        snap <= {hour_10, hour1, min_10, min1, sec_10, sec1};
        col  <= col ^ (sec1 != snap[0]);
      end
    end
  end

  always_comb begin
    cur = '0;
    case (idx)
      3'd0:    cur = snap[0];
      3'd1:    cur = snap[1];
      3'd2:    cur = snap[2];
      3'd3:    cur = snap[3];
      3'd4:    cur = snap[4];
      3'd5:    cur = snap[5];
      default: cur = '0;
    endcase
  end

  always_comb begin
    glyph = 7'h40;
    case (cur)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  end

  always_comb begin
    seg_a = glyph;
    if (BLANK_LZ && (idx == 3'd5) && (cur == 4'd0))
      seg_a = '0;
    dp_a  = col && ((idx == 3'd2) || (idx == 3'd4));
    dig_a = (cnt < GRD) ? 6'd0 : (6'd1 << idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg    <= {7{ACTIVE_LOW}};
      dp     <= ACTIVE_LOW;
      dig_en <= {6{ACTIVE_LOW}};
    end else begin
      seg    <= seg_a ^ {7{ACTIVE_LOW}};
      dp     <= dp_a ^ ACTIVE_LOW;
      dig_en <= dig_a ^ {6{ACTIVE_LOW}};
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: time-based frame model plus directed literal checks.
// Small SCAN_DIV keeps frames short (24 cycles).
module tb_seg7_scan;

  localparam int SD = 4;
  localparam int GD = 1;
  localparam int FR = 6 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] hour_10 = 0, hour1 = 0, min_10 = 0;
  logic [3:0] min1 = 0, sec_10 = 0, sec1 = 0;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;
  logic [5:0] dig_en, dig_nb;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  seg7_scan #(
    .SCAN_DIV(SD), .GUARD(GD), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst),
    .hour_10(hour_10), .hour1(hour1), .min_10(min_10),
    .min1(min1), .sec_10(sec_10), .sec1(sec1),
    .seg(seg), .dp(dp), .dig_en(dig_en)
  );

  seg7_scan #(
    .SCAN_DIV(SD), .GUARD(GD), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) u_nb (
    .clk(clk), .rst(rst),
    .hour_10(hour_10), .hour1(hour1), .min_10(min_10),
    .min1(min1), .sec_10(sec_10), .sec1(sec1),
    .seg(seg_nb), .dp(dp_nb), .dig_en(dig_nb)
  );

  function automatic logic [6:0] shape(input logic [3:0] v);
    case (v)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Model: elapsed cycles since reset determine slot and position
  int         t = 0;
  bit         armed = 0;
  bit         mcol = 0;
  logic [3:0] ms [6];
  logic [3:0] in_d [6];
  logic [6:0] e_seg;
  logic       e_dp;
  logic [5:0] e_dig;

  always @(posedge clk) begin
    int slot, pos;
    logic [6:0] lit;
    if (rst) begin
      t = 0;
      mcol = 0;
      foreach (ms[i]) ms[i] = 4'd0;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      e_dig = 6'h3F;
      armed = 1;
    end else begin
      slot = (t / SD) % 6;
      pos  = t % SD;
      lit  = shape(ms[slot]);
      if (slot == 5 && ms[5] == 4'd0) lit = 7'h00;
      e_seg = ~lit;
      e_dp  = ~(mcol && (slot == 2 || slot == 4));
      e_dig = (pos < GD) ? 6'h3F : ~(6'd1 << slot);
      if (t % FR == 0) begin
        in_d[0] = sec1;   in_d[1] = sec_10;
        in_d[2] = min1;   in_d[3] = min_10;
        in_d[4] = hour1;  in_d[5] = hour_10;
        if (in_d[0] != ms[0]) mcol = !mcol;
        foreach (ms[i]) ms[i] = in_d[i];
      end
      t++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if ({seg, dp, dig_en} == {e_seg, e_dp, e_dig})
        pass++;
      else
        $display("FAIL scan t=%0d got seg=%h dp=%b dig=%h want seg=%h dp=%b dig=%h",
                 t, seg, dp, dig_en, e_seg, e_dp, e_dig);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s got %h want %h", nm, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the next negedge where dig_en equals d (bounded)
  task automatic find(input logic [5:0] d, input string nm);
    int n = 0;
    @(negedge clk);
    while (dig_en != d && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (dig_en != d) begin
      total++;
      $display("FAIL %s timeout dig_en=%h want %h", nm, dig_en, d);
    end
  endtask

  task automatic set_time(input logic [3:0] a, b, c, d, e, f);
    hour_10 = a; hour1 = b; min_10 = c;
    min1 = d; sec_10 = e; sec1 = f;
  endtask

  initial begin
    set_time(1, 2, 3, 4, 5, 6);
    step(2);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_dig", {2'b0, dig_en}, 8'h3F);
    rst = 1'b0;
    step(1);
    chk("first_guard", {2'b0, dig_en}, 8'h3F);
    step(1);
    chk("first_dig0", {2'b0, dig_en}, 8'h3E);
    chk("sec1_6", {1'b0, seg}, 8'h02);
    find(6'h3D, "f_s10"); chk("sec10_5", {1'b0, seg}, 8'h12);
    find(6'h3B, "f_m1");  chk("min1_4", {1'b0, seg}, 8'h19);
    find(6'h37, "f_m10"); chk("min10_3", {1'b0, seg}, 8'h30);
    find(6'h2F, "f_h1");  chk("hour1_2", {1'b0, seg}, 8'h24);
    find(6'h1F, "f_h10"); chk("hour10_1", {1'b0, seg}, 8'h79);

    // Reset in the middle of a slot
    step(6);
    rst = 1'b1;
    step(1);
    chk("mid_rst_seg", {1'b0, seg}, 8'h7F);
    chk("mid_rst_dp", {7'b0, dp}, 8'h01);
    chk("mid_rst_dig", {2'b0, dig_en}, 8'h3F);
    step(2);
    chk("hold_rst_dig", {2'b0, dig_en}, 8'h3F);
    rst = 1'b0;
    step(1);
    chk("restart_guard", {2'b0, dig_en}, 8'h3F);
    step(1);
    chk("restart_dig0", {2'b0, dig_en}, 8'h3E);
    chk("restart_seg", {1'b0, seg}, 8'h02);

    // Leading-zero blanking, both settings
    set_time(0, 9, 0, 5, 0, 0);
    step(30);
    find(6'h1F, "f_lz");
    chk("lz_blank", {1'b0, seg}, 8'h7F);
    chk("lz_off", {1'b0, seg_nb}, 8'h40);
    find(6'h2F, "f_h1_9"); chk("hour1_9", {1'b0, seg}, 8'h10);

    // Out-of-range code shows a dash
    min1 = 4'hC;
    step(30);
    find(6'h3B, "f_bad"); chk("bad_bcd", {1'b0, seg}, 8'h3F);
    find(6'h37, "f_nb");  chk("bad_neigh", {1'b0, seg}, 8'h40);

    // Change mid-frame must wait for the next snapshot
    min1 = 4'd3;
    step(30);
    find(6'h3B, "f_s1");
    chk("stab_old0", {1'b0, seg}, 8'h30);
    min1 = 4'd7;
    step(1);
    chk("stab_old1", {1'b0, seg}, 8'h30);
    step(3);
    find(6'h3B, "f_s2");
    chk("stab_new", {1'b0, seg}, 8'h78);

    // Colon blink on sec1 change
    sec1 = 4'd1;
    step(30);
    find(6'h3B, "f_c1"); chk("col_on_m1", {7'b0, dp}, 8'h00);
    find(6'h2F, "f_c2"); chk("col_on_h1", {7'b0, dp}, 8'h00);
    find(6'h1F, "f_c3"); chk("col_h10", {7'b0, dp}, 8'h01);
    find(6'h3E, "f_c4"); chk("col_s1", {7'b0, dp}, 8'h01);
    find(6'h37, "f_c5"); chk("col_m10", {7'b0, dp}, 8'h01);
    sec1 = 4'd2;
    step(30);
    find(6'h3B, "f_c6"); chk("col_off_m1", {7'b0, dp}, 8'h01);
    find(6'h2F, "f_c7"); chk("col_off_h1", {7'b0, dp}, 8'h01);

    step(4);
    #1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
